// File: rtl/vga_scaler_if.sv
// ---------------------------------------------------------------------------
// vga_scaler_if
// Framebuffer fetch bus between the scaler and the pixel memory.
//
// Signals:
//   x_out   - source-pixel column requested from the framebuffer
//   y_out   - source-pixel row requested from the framebuffer
//   rd_en   - read strobe; the addressed pixel must be on rgb_in one
//             clock later
//   rgb_in  - packed pixel data returned by the framebuffer
//
// Modports:
//   master  - the scaler (drives address/strobe, receives data)
//   slave   - the framebuffer (receives address/strobe, drives data)
// ---------------------------------------------------------------------------
interface vga_scaler_if #(
  parameter int IN_W = 8
);
  logic [9:0]      x_out;
  logic [8:0]      y_out;
  logic            rd_en;
  logic [IN_W-1:0] rgb_in;

  modport master (
    output x_out,
    output y_out,
    output rd_en,
    input  rgb_in
  );

  modport slave (
    input  x_out,
    input  y_out,
    input  rd_en,
    output rgb_in
  );
endinterface

// File: rtl/vga_scaler.sv
// ---------------------------------------------------------------------------
// vga_scaler
// Integer up-scaler (1x / 2x / 4x) sitting between a VGA timing generator
// and a low-resolution framebuffer. Each source pixel is fetched once from
// memory on the first line of its vertical repeat group and kept in a
// one-line buffer; the remaining repeat lines replay that buffer so the
// framebuffer only sees one read per source pixel per source row. Packed
// colour fields are widened to OUT_BITS by MSB-first bit replication.
//
// Ports:
//   clk_in          - pixel clock, all state updates on the rising edge
//   rst_n           - asynchronous active-low reset
//   counterH        - horizontal position from the timing generator
//   counterV        - vertical position from the timing generator
//   mode            - scale select: 0=1x, 1=2x, 2=4x, 3=treated as 2x
//   fb              - framebuffer fetch bus (x_out, y_out, rd_en, rgb_in)
//   r, g, b         - expanded colour, registered, zero outside active video
//   de              - data enable aligned with r/g/b
//   frame_start     - one-cycle pulse after the frame origin is sampled
//   between_frames  - high while counterV is outside the active rows
//
// Pipeline (relative to the edge that samples the counters):
//   stage 0 (edge n)   : address, read strobe, active/first-line flags
//   stage 1 (edge n+1) : pixel taken from memory (and written to the line
//                        buffer) or read back from the line buffer
//   stage 2 (edge n+2) : colour expansion into r/g/b, de
// ---------------------------------------------------------------------------
module vga_scaler #(
  parameter int H_START  = 144,
  parameter int V_START  = 35,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int IN_RB    = 3,
  parameter int IN_GB    = 3,
  parameter int IN_BB    = 2,
  parameter int OUT_BITS = 8
) (
  input  logic                clk_in,
  input  logic                rst_n,
  input  logic [9:0]          counterH,
  input  logic [9:0]          counterV,
  input  logic [1:0]          mode,
  vga_scaler_if.master        fb,
  output logic [OUT_BITS-1:0] r,
  output logic [OUT_BITS-1:0] g,
  output logic [OUT_BITS-1:0] b,
  output logic                de,
  output logic                frame_start,
  output logic                between_frames
);

  localparam int IN_W = IN_RB + IN_GB + IN_BB;
  localparam int AW   = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;

  localparam logic [10:0] H_LO = 11'(H_START);
  localparam logic [10:0] H_HI = 11'(H_START + H_ACTIVE);
  localparam logic [10:0] V_LO = 11'(V_START);
  localparam logic [10:0] V_HI = 11'(V_START + V_ACTIVE);

  // Stage-0 registers (also drive the framebuffer bus)
  logic [9:0]      x_q;
  logic [8:0]      y_q;
  logic            rd_q;
  logic [1:0]      scale;

  // Stage-1 registers
  logic            act_s1;
  logic            de_s1;
  logic [IN_W-1:0] pix_s1;

  // Line buffer holding one source row; intentionally not reset, since the
  // first line of every repeat group refills it before it is replayed.
  logic [IN_W-1:0] line_buf [H_ACTIVE];

  // Combinational decode of the sampled counters
  logic            h_in;
  logic            v_in;
  logic            active;
  logic            first_line;
  logic            origin;
  logic [9:0]      h_rel;
  logic [9:0]      v_rel;
  logic [9:0]      rep_mask;
  logic [9:0]      x_next;
  logic [8:0]      y_next;
  logic [1:0]      mode_scale;
  logic [AW-1:0]   buf_addr;

  assign fb.x_out = x_q;
  assign fb.y_out = y_q;
  assign fb.rd_en = rd_q;

  assign buf_addr = AW'(x_q);

  // MSB-first replication of a 'width'-bit field held in the low bits of
  // 'field' out to OUT_BITS, so full-scale input maps to full-scale output.
  function automatic logic [OUT_BITS-1:0] expand(input logic [IN_W-1:0] field,
                                                 input int width);
    logic [OUT_BITS-1:0] res;
    res = '0;
    for (int i = 0; i < OUT_BITS; i++) begin
      res[OUT_BITS-1-i] = field[width-1-(i % width)];
    end
    return res;
  endfunction

  // Position decode: inclusive lower / exclusive upper window bounds, the
  // offsets into the active area, and the source address for this scale.
  // The repeat mask picks out the first line of each vertical group; with
  // scale 0 the mask is empty so every line fetches from memory.
  always_comb begin
    h_in       = ({1'b0, counterH} >= H_LO) && ({1'b0, counterH} < H_HI);
    v_in       = ({1'b0, counterV} >= V_LO) && ({1'b0, counterV} < V_HI);
    active     = h_in && v_in;
    origin     = (counterH == 10'd0) && (counterV == 10'd0);
    h_rel      = counterH - 10'(H_START);
    v_rel      = counterV - 10'(V_START);
    rep_mask   = (10'd1 << scale) - 10'd1;
    first_line = ((v_rel & rep_mask) == 10'd0);
    x_next     = h_rel >> scale;
    y_next     = 9'(v_rel >> scale);
  end

  // Mode decode; the reserved encoding falls back to 2x.
  always_comb begin
    mode_scale = 2'd1;
    case (mode)
      2'd0:    mode_scale = 2'd0;
      2'd1:    mode_scale = 2'd1;
      2'd2:    mode_scale = 2'd2;
      default: mode_scale = 2'd1;
    endcase
  end

  // Scale is only taken at the frame origin so a frame never mixes scales.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      scale <= 2'd1;
    end else if (origin) begin
      scale <= mode_scale;
    end
  end

  // Stage 0: framebuffer address and read strobe. The address holds during
  // blanking so the bus stays quiet between lines.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      x_q    <= '0;
      y_q    <= '0;
      rd_q   <= 1'b0;
      act_s1 <= 1'b0;
    end else begin
      rd_q   <= active && first_line;
      act_s1 <= active;
      if (active) begin
        x_q <= x_next;
        y_q <= y_next;
      end
    end
  end

  // Frame markers, both one cycle behind the counters.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      frame_start    <= 1'b0;
      between_frames <= 1'b1;
    end else begin
      frame_start    <= origin;
      between_frames <= !v_in;
    end
  end

  // Stage 1: memory data arrives this cycle on fetch lines; repeat lines
  // replay the buffered row with the same timing. rd_q doubles as the
  // "this pixel comes from memory" flag because it is only ever set on
  // active fetch-line cycles.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      de_s1  <= 1'b0;
      pix_s1 <= '0;
    end else begin
      de_s1 <= act_s1;
      if (act_s1) begin
        pix_s1 <= rd_q ? fb.rgb_in : line_buf[buf_addr];
      end
    end
  end

  // Line buffer fill. Writes happen only on fetch lines and reads only on
  // repeat lines, so a same-address read/write collision cannot occur.
  always_ff @(posedge clk_in) begin
    if (act_s1 && rd_q) begin
      line_buf[buf_addr] <= fb.rgb_in;
    end
  end

  // Stage 2: colour expansion; blanking forces black.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r  <= '0;
      g  <= '0;
      b  <= '0;
      de <= 1'b0;
    end else begin
      de <= de_s1;
      if (de_s1) begin
        r <= expand(IN_W'(pix_s1[IN_W-1 -: IN_RB]), IN_RB);
        g <= expand(IN_W'(pix_s1[IN_BB +: IN_GB]), IN_GB);
        b <= expand(IN_W'(pix_s1[0 +: IN_BB]), IN_BB);
      end else begin
        r <= '0;
        g <= '0;
        b <= '0;
      end
    end
  end

endmodule

// File: tb/tb_vga_scaler.sv
// ---------------------------------------------------------------------------
// tb_vga_scaler
// Directed bench for vga_scaler with default parameters. Counters are driven
// directly (jumps are legal), one sample per clock. The framebuffer is a
// combinational pattern of the requested address that returns zero whenever
// rd_en is low, so a replay from the line buffer is distinguishable from a
// bogus memory read.
//
// Pattern pixel: {x[2:0]^3'b101, 3'b011, y[1:0]^2'b10}
//   (x=0,y=0) -> 101_011_10 : r=B6 g=6D b=AA
//   (x=1,y=0) -> 100_011_10 : r=92 g=6D b=AA
// Forced pixel 101_010_11 : r=B6 g=49 b=FF
// ---------------------------------------------------------------------------
module tb_vga_scaler;

  logic       clk_in;
  logic       rst_n;
  logic [9:0] counterH;
  logic [9:0] counterV;
  logic [1:0] mode;
  logic [7:0] r;
  logic [7:0] g;
  logic [7:0] b;
  logic       de;
  logic       frame_start;
  logic       between_frames;

  logic       force_en;
  logic [7:0] force_pix;

  int tests_run;
  int tests_failed;

  vga_scaler_if #(.IN_W(8)) fb ();

  vga_scaler dut (
    .clk_in         (clk_in),
    .rst_n          (rst_n),
    .counterH       (counterH),
    .counterV       (counterV),
    .mode           (mode),
    .fb             (fb.master),
    .r              (r),
    .g              (g),
    .b              (b),
    .de             (de),
    .frame_start    (frame_start),
    .between_frames (between_frames)
  );

  // Framebuffer model
  assign fb.rgb_in = !fb.rd_en ? 8'h00 :
                     force_en  ? force_pix :
                     {fb.x_out[2:0] ^ 3'b101, 3'b011, fb.y_out[1:0] ^ 2'b10};

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Drive one counter sample, let it be clocked in, then settle past the edge
  task automatic applyStimulus(input logic [9:0] h, input logic [9:0] v,
                               input logic [1:0] m);
    counterH = h;
    counterV = v;
    mode     = m;
    @(posedge clk_in);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    force_en     = 1'b0;
    force_pix    = 8'h00;
    counterH     = 10'd0;
    counterV     = 10'd0;
    mode         = 2'd1;
    rst_n        = 1'b0;

    // Reset state
    #12;
    checkOutput("rst_x_out",    32'(fb.x_out), 32'd0);
    checkOutput("rst_y_out",    32'(fb.y_out), 32'd0);
    checkOutput("rst_rd_en",    32'(fb.rd_en), 32'd0);
    checkOutput("rst_rgb",      32'({r, g, b}), 32'd0);
    checkOutput("rst_de",       32'(de), 32'd0);
    checkOutput("rst_fs",       32'(frame_start), 32'd0);
    checkOutput("rst_between",  32'(between_frames), 32'd1);

    @(negedge clk_in);
    rst_n = 1'b1;
    @(posedge clk_in);
    #1;

    // 2x frame: origin, then row V_START
    applyStimulus(10'd0, 10'd0, 2'd1);
    checkOutput("fs_2x",        32'(frame_start), 32'd1);
    checkOutput("between_v0",   32'(between_frames), 32'd1);
    applyStimulus(10'd144, 10'd35, 2'd1);
    checkOutput("fs_drop",      32'(frame_start), 32'd0);
    checkOutput("between_v35",  32'(between_frames), 32'd0);
    checkOutput("x_144",        32'(fb.x_out), 32'd0);
    checkOutput("y_row35",      32'(fb.y_out), 32'd0);
    checkOutput("rd_144",       32'(fb.rd_en), 32'd1);
    applyStimulus(10'd145, 10'd35, 2'd1);
    checkOutput("x_145",        32'(fb.x_out), 32'd0);
    checkOutput("rd_145",       32'(fb.rd_en), 32'd1);
    checkOutput("de_early",     32'(de), 32'd0);
    applyStimulus(10'd146, 10'd35, 2'd1);
    checkOutput("x_146",        32'(fb.x_out), 32'd1);
    checkOutput("rd_146",       32'(fb.rd_en), 32'd1);
    checkOutput("de_lat2",      32'(de), 32'd1);
    checkOutput("rgb_r35_p0",   32'({r, g, b}), 32'hB66DAA);
    applyStimulus(10'd147, 10'd35, 2'd1);
    checkOutput("x_147",        32'(fb.x_out), 32'd1);
    checkOutput("rd_147",       32'(fb.rd_en), 32'd1);
    checkOutput("rgb_r35_p1",   32'({r, g, b}), 32'hB66DAA);
    applyStimulus(10'd10, 10'd35, 2'd1);
    checkOutput("rd_blank",     32'(fb.rd_en), 32'd0);
    checkOutput("x_hold",       32'(fb.x_out), 32'd1);
    checkOutput("rgb_r35_p2",   32'({r, g, b}), 32'h926DAA);
    applyStimulus(10'd10, 10'd35, 2'd1);
    checkOutput("rgb_r35_p3",   32'({r, g, b}), 32'h926DAA);
    applyStimulus(10'd10, 10'd35, 2'd1);
    checkOutput("de_blank",     32'(de), 32'd0);
    checkOutput("rgb_blank",    32'({r, g, b}), 32'd0);

    // Row V_START+1 replays the line buffer
    applyStimulus(10'd144, 10'd36, 2'd1);
    checkOutput("rd_rep_144",   32'(fb.rd_en), 32'd0);
    checkOutput("y_rep",        32'(fb.y_out), 32'd0);
    applyStimulus(10'd145, 10'd36, 2'd1);
    checkOutput("rd_rep_145",   32'(fb.rd_en), 32'd0);
    applyStimulus(10'd146, 10'd36, 2'd1);
    checkOutput("rd_rep_146",   32'(fb.rd_en), 32'd0);
    checkOutput("rgb_r36_p0",   32'({r, g, b}), 32'hB66DAA);
    applyStimulus(10'd147, 10'd36, 2'd1);
    checkOutput("rgb_r36_p1",   32'({r, g, b}), 32'hB66DAA);
    applyStimulus(10'd10, 10'd36, 2'd1);
    checkOutput("rgb_r36_p2",   32'({r, g, b}), 32'h926DAA);
    applyStimulus(10'd10, 10'd36, 2'd1);
    checkOutput("rgb_r36_p3",   32'({r, g, b}), 32'h926DAA);

    // 1x frame with a fixed pixel; mode change mid-frame has no effect
    force_en  = 1'b1;
    force_pix = 8'b101_010_11;
    applyStimulus(10'd0, 10'd0, 2'd0);
    checkOutput("fs_1x",        32'(frame_start), 32'd1);
    applyStimulus(10'd200, 10'd40, 2'd0);
    checkOutput("x_1x",         32'(fb.x_out), 32'd56);
    checkOutput("y_1x",         32'(fb.y_out), 32'd5);
    checkOutput("rd_1x",        32'(fb.rd_en), 32'd1);
    applyStimulus(10'd201, 10'd40, 2'd2);
    checkOutput("x_1x_midchg",  32'(fb.x_out), 32'd57);
    checkOutput("y_1x_midchg",  32'(fb.y_out), 32'd5);
    applyStimulus(10'd5, 10'd40, 2'd2);
    checkOutput("rgb_expand0",  32'({r, g, b}), 32'hB649FF);
    checkOutput("de_expand0",   32'(de), 32'd1);
    checkOutput("x_hold_1x",    32'(fb.x_out), 32'd57);
    applyStimulus(10'd5, 10'd40, 2'd2);
    checkOutput("rgb_expand1",  32'({r, g, b}), 32'hB649FF);
    applyStimulus(10'd5, 10'd40, 2'd2);
    checkOutput("rgb_off",      32'({r, g, b}), 32'd0);
    checkOutput("de_off",       32'(de), 32'd0);
    force_en = 1'b0;

    // 4x frame: repeat groups of four lines, window boundaries
    applyStimulus(10'd0, 10'd0, 2'd2);
    checkOutput("fs_4x",        32'(frame_start), 32'd1);
    applyStimulus(10'd200, 10'd38, 2'd2);
    checkOutput("rd_4x_row3",   32'(fb.rd_en), 32'd0);
    checkOutput("y_4x_row3",    32'(fb.y_out), 32'd0);
    checkOutput("x_4x",         32'(fb.x_out), 32'd14);
    applyStimulus(10'd200, 10'd39, 2'd2);
    checkOutput("rd_4x_row4",   32'(fb.rd_en), 32'd1);
    checkOutput("y_4x_row4",    32'(fb.y_out), 32'd1);
    applyStimulus(10'd783, 10'd39, 2'd2);
    checkOutput("x_h_last",     32'(fb.x_out), 32'd159);
    checkOutput("rd_h_last",    32'(fb.rd_en), 32'd1);
    applyStimulus(10'd784, 10'd39, 2'd2);
    checkOutput("rd_h_end",     32'(fb.rd_en), 32'd0);
    checkOutput("x_h_end_hold", 32'(fb.x_out), 32'd159);
    applyStimulus(10'd143, 10'd39, 2'd2);
    checkOutput("rd_h_before",  32'(fb.rd_en), 32'd0);
    applyStimulus(10'd200, 10'd515, 2'd2);
    checkOutput("between_515",  32'(between_frames), 32'd1);
    checkOutput("rd_v_end",     32'(fb.rd_en), 32'd0);
    applyStimulus(10'd200, 10'd514, 2'd2);
    checkOutput("between_514",  32'(between_frames), 32'd0);
    checkOutput("y_v_last",     32'(fb.y_out), 32'd119);
    checkOutput("rd_v_last",    32'(fb.rd_en), 32'd0);
    applyStimulus(10'd201, 10'd514, 2'd2);
    applyStimulus(10'd202, 10'd514, 2'd2);
    checkOutput("de_pre_rst",   32'(de), 32'd1);

    // Asynchronous reset mid-line
    rst_n = 1'b0;
    #2;
    checkOutput("arst_x",       32'(fb.x_out), 32'd0);
    checkOutput("arst_y",       32'(fb.y_out), 32'd0);
    checkOutput("arst_rd",      32'(fb.rd_en), 32'd0);
    checkOutput("arst_de",      32'(de), 32'd0);
    checkOutput("arst_rgb",     32'({r, g, b}), 32'd0);
    checkOutput("arst_between", 32'(between_frames), 32'd1);
    @(negedge clk_in);
    rst_n = 1'b1;

    // Scale is 2x after release even though mode selects 4x
    applyStimulus(10'd200, 10'd41, 2'd2);
    checkOutput("post_rst_rd",  32'(fb.rd_en), 32'd1);
    checkOutput("post_rst_y",   32'(fb.y_out), 32'd3);
    checkOutput("post_rst_x",   32'(fb.x_out), 32'd28);

    // Reserved mode latches 2x
    applyStimulus(10'd0, 10'd0, 2'd3);
    checkOutput("fs_mode3",     32'(frame_start), 32'd1);
    applyStimulus(10'd148, 10'd35, 2'd3);
    checkOutput("x_mode3",      32'(fb.x_out), 32'd2);
    checkOutput("rd_mode3",     32'(fb.rd_en), 32'd1);
    applyStimulus(10'd148, 10'd36, 2'd3);
    checkOutput("rd_mode3_rep", 32'(fb.rd_en), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/vga_scaler.md
VGA_SCALER -- requirements
Module: vga_scaler

Interface
REQ-001 Parameter H_START, default 144: first active counterH value.
REQ-002 Parameter V_START, default 35: first active counterV value.
REQ-003 Parameter H_ACTIVE, default 640: active pixels per line.
REQ-004 Parameter V_ACTIVE, default 480: active lines per frame.
REQ-005 Parameter IN_RB, default 3; IN_GB, default 3; IN_BB, default 2: packed red/green/blue field widths of rgb_in, R in MSBs.
REQ-006 Parameter OUT_BITS, default 8: output width per colour channel.
REQ-007 clk_in  input  1  pixel clock; all state updates on rising edge.
REQ-008 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-009 counterH  input  10  horizontal position from timing generator.
REQ-010 counterV  input  10  vertical position from timing generator.
REQ-011 mode  input  2  scale select: 0=1x, 1=2x, 2=4x, 3=reserved.
REQ-012 x_out  output  10  source-pixel column to framebuffer.
REQ-013 y_out  output  9  source-pixel row to framebuffer.
REQ-014 rd_en  output  1  framebuffer read strobe; data returns on rgb_in exactly 1 cycle later.
REQ-015 rgb_in  input  IN_RB+IN_GB+IN_BB  framebuffer pixel data.
REQ-016 r, g, b  output  OUT_BITS each  expanded colour, registered.
REQ-017 de  output  1  data-enable aligned with r/g/b.
REQ-018 frame_start  output  1  single-cycle pulse at frame origin.
REQ-019 between_frames  output  1  high while counterV outside active rows.

Function
REQ-020 Active cycle: H_START <= counterH < H_START+H_ACTIVE and V_START <= counterV < V_START+V_ACTIVE; inclusive lower, exclusive upper bounds.
REQ-021 Scale shift s latched from mode only when counterH==0 and counterV==0 (s=0,1,2 for mode 0,1,2; mode 3 latches s=1); mode changes mid-frame have no effect until next origin.
REQ-022 Stage 0 (cycle of counter sample): x_out <= (counterH-H_START)>>s, y_out <= (counterV-V_START)>>s on active cycles; x_out/y_out hold value on non-active cycles.
REQ-023 First-repeat line: active line with ((counterV-V_START) & ((1<<s)-1))==0; with s=0 every line is first-repeat.
REQ-024 rd_en asserted in stage 0 on active cycles of first-repeat lines only; deasserted on all other cycles.
REQ-025 Stage 1: on first-repeat lines, rgb_in captured and written to internal line buffer (depth H_ACTIVE, indexed by x_out); on repeat lines, pixel read from line buffer at x_out with identical timing.
REQ-026 Stage 2: r/g/b/de registered; total latency counters->r/g/b/de = 2 cycles, identical for memory and line-buffer paths.
REQ-027 Colour expansion by MSB-first bit replication of each field to OUT_BITS (3-bit 101 -> 10110110; 2-bit 10 -> 10101010; all-ones -> all-ones; zero -> zero).
REQ-028 de=0 forces r=g=b=0.
REQ-029 frame_start pulses 1 cycle, 1 cycle after counterH==0 and counterV==0 sampled.
REQ-030 between_frames registered, 1-cycle latency, equals NOT (V_START <= counterV < V_START+V_ACTIVE).
REQ-031 Counter jumps (non-monotonic input) produce no illegal state: outputs follow REQ-020..REQ-028 for the sampled values only.
REQ-032 Line-buffer write and read of same address in one cycle cannot occur (writes only on first-repeat lines, reads only on repeat lines).

Reset
REQ-033 rst_n low asynchronously clears x_out, y_out, rd_en, r, g, b, de, frame_start to 0, between_frames to 1, latched s to 1 (2x).
REQ-034 Line-buffer contents not reset; first frame after reset with s>0 fetches from memory before any buffer read, so stale data is never displayed.
REQ-035 Reset deassertion mid-frame: outputs resume per REQ-020..REQ-030 on first rising edge after release; s stays 1 until next frame origin.

Verification
REQ-036 mode=1, counterH=H_START..H_START+3 on row V_START -> x_out 0,0,1,1; rd_en=1 each cycle; de high 2 cycles after each sample.
REQ-037 mode=1, row V_START+1 -> rd_en=0 throughout; r/g/b identical to row V_START pixel-for-pixel.
REQ-038 mode=2 latched at origin; row V_START+3 -> rd_en=0, y_out=0; row V_START+4 -> rd_en=1, y_out=1.
REQ-039 rgb_in=8'b101_010_11 during active -> r=8'hB6, g=8'h49, b=8'hFF two cycles later; blanking -> r=g=b=0, de=0.
REQ-040 mode changed 0->2 mid-frame -> scaling remains 1x until counterH=0,counterV=0, frame_start pulses, then 4x.
REQ-041 rst_n pulsed low mid-line -> all outputs at reset values immediately, between_frames=1; normal 2x output on next frame.
